// File: rtl/otter_dmem_pkg.sv
// Shared definitions for the OTTER data-memory responder.
//   - MMIO register offsets (word aligned, relative to MMIO_BASE)
//   - region_t: address decode result
//   - lane_merge(): byte-lane write merge used by RAM-adjacent registers and the timer
package otter_dmem_pkg;

  localparam logic [11:0] OFS_LEDS        = 12'h000;
  localparam logic [11:0] OFS_SWITCHES    = 12'h004;
  localparam logic [11:0] OFS_MTIME_LO    = 12'h008;
  localparam logic [11:0] OFS_MTIME_HI    = 12'h00C;
  localparam logic [11:0] OFS_MTIMECMP_LO = 12'h010;
  localparam logic [11:0] OFS_MTIMECMP_HI = 12'h014;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

  // Replace each byte of old_word whose sel bit is set with the matching byte of new_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/otter_dmem_mtimer.sv
// Machine timer for otter_dmem: 64-bit free-running mtime, 64-bit mtimecmp and a registered
// level interrupt (mtime >= mtimecmp, unsigned), lagging the registers by one cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mtime_we_lo/hi           byte-lane write strobes for the two mtime halves
//   cmp_we_lo/hi             byte-lane write strobes for the two mtimecmp halves
//   sel, w_data              byte-lane enables and write data
//   mtime, mtimecmp          current register values (for MMIO reads)
//   irq                      registered timer interrupt
module otter_mtimer
  import otter_dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_we_lo,
  input  logic        mtime_we_hi,
  input  logic        cmp_we_lo,
  input  logic        cmp_we_hi,
  input  logic [3:0]  sel,
  input  logic [31:0] w_data,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q;

  // A write to either half replaces the increment for that cycle; the untouched half holds,
  // so no carry crosses into it.
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (mtime_we_lo) begin
      mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], w_data, sel)};
    end else if (mtime_we_hi) begin
      mtime_d = {lane_merge(mtime_q[63:32], w_data, sel), mtime_q[31:0]};
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (cmp_we_lo) begin
      cmp_d = {cmp_q[63:32], lane_merge(cmp_q[31:0], w_data, sel)};
    end else if (cmp_we_hi) begin
      cmp_d = {lane_merge(cmp_q[63:32], w_data, sel), cmp_q[31:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign irq      = irq_q;

endmodule

// File: rtl/otter_dmem.sv
// Data-memory responder for the OTTER MCU data port.
// Decodes each access into byte-writable RAM, an MMIO bank (LEDs, switches, machine timer) or
// unmapped space. Read data is registered (1-cycle latency, read-first on same-address writes);
// unmapped accesses read 0, drop writes and pulse o_bus_err for one cycle.
// Build option: define OTTER_DMEM_TIMER_EN to include the machine timer (otter_mtimer);
// without it the timer offsets are unmapped and o_timer_irq is tied low.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_dmem_re / i_dmem_we       read / write request
//   i_dmem_sel                  byte-lane write enables
//   i_dmem_addr, i_dmem_w_data  byte address (bits [1:0] ignored), write data
//   o_dmem_r_data               registered read word
//   o_bus_err                   one-cycle unmapped-access pulse
//   i_switches, o_leds          board I/O
//   o_timer_irq                 machine timer interrupt (level)
module otter_dmem
  import otter_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1100_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dmem_re,
  input  logic        i_dmem_we,
  input  logic [3:0]  i_dmem_sel,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_w_data,
  output logic [31:0] o_dmem_r_data,
  output logic        o_bus_err,
  input  logic [15:0] i_switches,
  output logic [15:0] o_leds,
  output logic        o_timer_irq
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic [11:0]   ofs;
  logic          unused_addr_lsb;
  region_t       region;

  logic          mmio_hit;
  logic [31:0]   mmio_rdata;
  logic [31:0]   rd_word;
  logic          bad_access;
  logic          ram_we;
  logic          leds_we;
  logic [31:0]   leds_merged;

  logic [31:0]   r_data_q;
  logic          bus_err_q;
  logic [15:0]   leds_q;

  assign ram_idx         = i_dmem_addr[AW+1:2];
  assign ofs             = {i_dmem_addr[11:2], 2'b00};
  assign unused_addr_lsb = ^i_dmem_addr[1:0];

  // addr < DEPTH_WORDS*4 is the same as addr[31:2] < DEPTH_WORDS, which avoids overflow.
  always_comb begin
    region = REG_NONE;
    if ({1'b0, i_dmem_addr[31:2]} < 31'(DEPTH_WORDS)) begin
      region = REG_RAM;
    end else if (i_dmem_addr[31:12] == MMIO_BASE[31:12]) begin
      region = REG_MMIO;
    end
  end

`ifdef OTTER_DMEM_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        timer_irq;
  logic        mmio_we;

  assign mmio_we = i_dmem_we && (region == REG_MMIO);

  otter_mtimer u_mtimer (
    .clk         (i_clk),
    .rst         (i_rst),
    .mtime_we_lo (mmio_we && (ofs == OFS_MTIME_LO)),
    .mtime_we_hi (mmio_we && (ofs == OFS_MTIME_HI)),
    .cmp_we_lo   (mmio_we && (ofs == OFS_MTIMECMP_LO)),
    .cmp_we_hi   (mmio_we && (ofs == OFS_MTIMECMP_HI)),
    .sel         (i_dmem_sel),
    .w_data      (i_dmem_w_data),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .irq         (timer_irq)
  );

  assign o_timer_irq = timer_irq;
`else
  assign o_timer_irq = 1'b0;
`endif

  always_comb begin
    mmio_hit   = 1'b1;
    mmio_rdata = '0;
    case (ofs)
      OFS_LEDS:        mmio_rdata = {16'h0000, leds_q};
      OFS_SWITCHES:    mmio_rdata = {16'h0000, i_switches};
`ifdef OTTER_DMEM_TIMER_EN
      OFS_MTIME_LO:    mmio_rdata = mtime[31:0];
      OFS_MTIME_HI:    mmio_rdata = mtime[63:32];
      OFS_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      OFS_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
`endif
      default:         mmio_hit   = 1'b0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (region)
      REG_RAM:  rd_word = mem[ram_idx];
      REG_MMIO: rd_word = mmio_rdata;
      default:  rd_word = '0;
    endcase
  end

  assign bad_access  = (i_dmem_re || i_dmem_we) &&
                       ((region == REG_NONE) || ((region == REG_MMIO) && !mmio_hit));
  assign ram_we      = i_dmem_we && (region == REG_RAM);
  assign leds_we     = i_dmem_we && (region == REG_MMIO) && (ofs == OFS_LEDS);
  assign leds_merged = lane_merge({16'h0000, leds_q}, i_dmem_w_data, i_dmem_sel);

  // RAM contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_dmem_sel[i]) mem[ram_idx][8*i +: 8] <= i_dmem_w_data[8*i +: 8];
      end
    end
  end

  // r_data samples the pre-write word, giving read-first behaviour on same-address writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_q  <= '0;
      bus_err_q <= 1'b0;
      leds_q    <= '0;
    end else begin
      if (i_dmem_re) r_data_q <= rd_word;
      bus_err_q <= bad_access;
      if (leds_we) leds_q <= leds_merged[15:0];
    end
  end

  assign o_dmem_r_data = r_data_q;
  assign o_bus_err     = bus_err_q;
  assign o_leds        = leds_q;

endmodule

// File: tb/tb_otter_dmem.sv
// Self-checking bench for otter_dmem: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the memory map, timer and read pipeline.
module tb_otter_dmem;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] MMIO  = 32'h1100_0000;
`ifdef OTTER_DMEM_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_dmem_re = 1'b0;
  logic        i_dmem_we = 1'b0;
  logic [3:0]  i_dmem_sel = 4'h0;
  logic [31:0] i_dmem_addr = 32'h0;
  logic [31:0] i_dmem_w_data = 32'h0;
  logic [31:0] o_dmem_r_data;
  logic        o_bus_err;
  logic [15:0] i_switches = 16'h0;
  logic [15:0] o_leds;
  logic        o_timer_irq;

  otter_dmem #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (MMIO)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_dmem_re     (i_dmem_re),
    .i_dmem_we     (i_dmem_we),
    .i_dmem_sel    (i_dmem_sel),
    .i_dmem_addr   (i_dmem_addr),
    .i_dmem_w_data (i_dmem_w_data),
    .o_dmem_r_data (o_dmem_r_data),
    .o_bus_err     (o_bus_err),
    .i_switches    (i_switches),
    .o_leds        (o_leds),
    .o_timer_irq   (o_timer_irq)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [int];
  logic [15:0] m_leds;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] exp_rdata;
  bit          exp_known;
  logic        exp_err;
  logic        exp_irq;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_leds    = 16'h0;
    m_mtime   = 64'h0;
    m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_rdata = 32'h0;
    exp_known = 1'b1;
    exp_err   = 1'b0;
    exp_irq   = 1'b0;
  endtask

  // kind: 0 ram, 1 leds, 2 switches, 3 mtime lo, 4 mtime hi, 5 cmp lo, 6 cmp hi, -1 unmapped
  function automatic int classify(input logic [31:0] a);
    logic [11:0] o;
    if ({32'h0, a} < 64'(DEPTH) * 64'd4) return 0;
    if (a[31:12] != MMIO[31:12]) return -1;
    o = a[11:0] & 12'hFFC;
    if (o == 12'h000) return 1;
    if (o == 12'h004) return 2;
    if (TimerEn) begin
      if (o == 12'h008) return 3;
      if (o == 12'h00C) return 4;
      if (o == 12'h010) return 5;
      if (o == 12'h014) return 6;
    end
    return -1;
  endfunction

  task automatic model_step();
    int          k;
    int          idx;
    logic [31:0] rd;
    bit          rd_known;
    bit          mt_written;
    if (i_rst) begin
      model_reset();
      return;
    end
    k        = classify(i_dmem_addr);
    idx      = int'(i_dmem_addr >> 2);
    rd       = 32'h0;
    rd_known = 1'b1;
    case (k)
      0: if (m_ram.exists(idx)) rd = m_ram[idx]; else rd_known = 1'b0;
      1: rd = {16'h0, m_leds};
      2: rd = {16'h0, i_switches};
      3: rd = m_mtime[31:0];
      4: rd = m_mtime[63:32];
      5: rd = m_cmp[31:0];
      6: rd = m_cmp[63:32];
      default: rd = 32'h0;
    endcase
    if (i_dmem_re) begin
      exp_rdata = rd;
      exp_known = rd_known;
    end
    exp_err    = (i_dmem_re || i_dmem_we) && (k < 0);
    exp_irq    = TimerEn && (m_mtime >= m_cmp);
    mt_written = 1'b0;
    if (i_dmem_we) begin
      case (k)
        0: m_ram[idx] = merge(m_ram.exists(idx) ? m_ram[idx] : 32'h0, i_dmem_w_data, i_dmem_sel);
        1: m_leds = 16'(merge({16'h0, m_leds}, i_dmem_w_data, i_dmem_sel));
        3: begin m_mtime[31:0]  = merge(m_mtime[31:0], i_dmem_w_data, i_dmem_sel); mt_written = 1; end
        4: begin m_mtime[63:32] = merge(m_mtime[63:32], i_dmem_w_data, i_dmem_sel); mt_written = 1; end
        5: m_cmp[31:0]  = merge(m_cmp[31:0], i_dmem_w_data, i_dmem_sel);
        6: m_cmp[63:32] = merge(m_cmp[63:32], i_dmem_w_data, i_dmem_sel);
        default: ;
      endcase
    end
    if (TimerEn && !mt_written) m_mtime = m_mtime + 64'd1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (exp_known) check("r_data", 64'(o_dmem_r_data), 64'(exp_rdata));
    check("bus_err", 64'(o_bus_err), 64'(exp_err));
    check("leds", 64'(o_leds), 64'(m_leds));
    check("timer_irq", 64'(o_timer_irq), 64'(exp_irq));
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    compare();
  endtask

  task automatic access(input logic re, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] data);
    i_dmem_re     = re;
    i_dmem_we     = we;
    i_dmem_sel    = sel;
    i_dmem_addr   = addr;
    i_dmem_w_data = data;
    cycle();
    i_dmem_re = 1'b0;
    i_dmem_we = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    int          w;
    logic [31:0] lo;
    logic [31:0] ofs_list [6];
    logic [31:0] bad_list [5];
    ofs_list = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014};
    bad_list = '{32'h8000_0000, 32'h0000_4000, MMIO + 32'h018, MMIO + 32'hFFC, MMIO + 32'h1000};
    lo = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      1: return MMIO + ofs_list[$urandom_range(0, 5)] + lo;
      2: return bad_list[$urandom_range(0, 4)];
      default: begin
        w = $urandom_range(0, 8);
        if (w == 8) w = DEPTH - 1;
        return 32'(w) * 4 + lo;
      end
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    model_reset();
    cycle();
    cycle();
    check("reset_r_data", 64'(o_dmem_r_data), 64'h0);
    check("reset_leds", 64'(o_leds), 64'h0);
    i_rst = 1'b0;

`ifdef OTTER_DMEM_TIMER_EN
    // irq rises 11 cycles after mtime is cleared with mtimecmp = 10
    access(0, 1, 4'hF, MMIO + 32'h014, 32'h0);
    access(0, 1, 4'hF, MMIO + 32'h010, 32'd10);
    access(0, 1, 4'hF, MMIO + 32'h008, 32'h0);
    check("irq_low_after_load", 64'(o_timer_irq), 64'h0);
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (o_timer_irq && rise == 0) rise = k;
    end
    check("irq_rise_cycle", 64'(rise), 64'd11);
    // wrap of mtime
    access(0, 1, 4'hF, MMIO + 32'h00C, 32'hFFFF_FFFF);
    access(0, 1, 4'hF, MMIO + 32'h008, 32'hFFFF_FFFF);
    access(1, 0, 4'h0, MMIO + 32'h008, 32'h0);
    check("mtime_lo_max", 64'(o_dmem_r_data), 64'hFFFF_FFFF);
    access(1, 0, 4'h0, MMIO + 32'h00C, 32'h0);
    check("mtime_hi_wrapped", 64'(o_dmem_r_data), 64'h0);
    access(1, 0, 4'h0, MMIO + 32'h008, 32'h0);
    check("mtime_lo_after_wrap", 64'(o_dmem_r_data), 64'h1);
`else
    access(1, 0, 4'h0, MMIO + 32'h008, 32'h0);
    check("mtime_unmapped_data", 64'(o_dmem_r_data), 64'h0);
    check("mtime_unmapped_err", 64'(o_bus_err), 64'h1);
`endif

    // byte-lane store/load
    access(0, 1, 4'hF, 32'h100, 32'hAABB_CCDD);
    access(0, 1, 4'b0101, 32'h100, 32'h1122_3344);
    access(1, 0, 4'h0, 32'h100, 32'h0);
    check("byte_lanes", 64'(o_dmem_r_data), 64'hAA22_CC44);

    // read-first conflict
    access(0, 1, 4'hF, 32'h200, 32'h0);
    access(1, 1, 4'hF, 32'h200, 32'h5);
    check("read_first_old", 64'(o_dmem_r_data), 64'h0);
    access(1, 0, 4'h0, 32'h200, 32'h0);
    check("read_first_new", 64'(o_dmem_r_data), 64'h5);

    // MMIO LEDs and switches
    access(0, 1, 4'hF, MMIO, 32'hFFFF_1234);
    check("leds_out", 64'(o_leds), 64'h1234);
    access(1, 0, 4'h0, MMIO, 32'h0);
    check("leds_read", 64'(o_dmem_r_data), 64'h0000_1234);
    i_switches = 16'hBEEF;
    access(1, 0, 4'h0, MMIO + 32'h004, 32'h0);
    check("switches_read", 64'(o_dmem_r_data), 64'h0000_BEEF);

    // unmapped
    access(1, 0, 4'h0, 32'h8000_0000, 32'h0);
    check("unmapped_rdata", 64'(o_dmem_r_data), 64'h0);
    check("unmapped_err", 64'(o_bus_err), 64'h1);
    cycle();
    check("err_one_cycle", 64'(o_bus_err), 64'h0);
    access(0, 1, 4'hF, 32'h8000_0000, 32'h0000_5555);
    check("unmapped_wr_err", 64'(o_bus_err), 64'h1);
    check("unmapped_wr_leds", 64'(o_leds), 64'h1234);

    // give every randomly addressed RAM word a defined value
    for (int w = 0; w < 8; w++) access(0, 1, 4'hF, 32'(w) * 4, $urandom);
    access(0, 1, 4'hF, 32'(DEPTH - 1) * 4, $urandom);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        i_dmem_re   = 1'b1;
        i_dmem_we   = 1'b1;
        i_dmem_addr = MMIO;
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_r_data", 64'(o_dmem_r_data), 64'h0);
        check("async_rst_err", 64'(o_bus_err), 64'h0);
        check("async_rst_leds", 64'(o_leds), 64'h0);
        check("async_rst_irq", 64'(o_timer_irq), 64'h0);
        model_reset();
        i_dmem_re = 1'b0;
        i_dmem_we = 1'b0;
        cycle();
        cycle();
        i_rst = 1'b0;
        access(1, 0, 4'h0, 32'h100, 32'h0);
        check("ram_kept_over_reset", 64'(o_dmem_r_data), 64'hAA22_CC44);
      end
      if ($urandom_range(0, 15) == 0) i_switches = 16'($urandom);
      i_dmem_re     = 1'($urandom_range(0, 1));
      i_dmem_we     = ($urandom_range(0, 2) == 0);
      i_dmem_sel    = 4'($urandom);
      i_dmem_addr   = pick_addr();
      i_dmem_w_data = $urandom;
      cycle();
    end
    i_dmem_re = 1'b0;
    i_dmem_we = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
